// File: rtl/cue_pkg.sv
// rtl/cue_pkg.sv - shared types, widths and arithmetic helpers for the cue aim controller
package cue_pkg;

    typedef enum logic [1:0] {WAIT_REST, AIM, CHARGE, FIRE} cue_state_e;

    localparam int ANGLE_STEPS = 64;
    localparam int ANGLE_W     = $clog2(ANGLE_STEPS);
    localparam int FRAC_W      = 7;
    localparam int TRIG_W      = 8;
    localparam int COORD_W     = 11;
    localparam int POWER_W     = 8;
    localparam int LEN_W       = 9;
    localparam int PROD_W      = 18;

    function automatic logic [POWER_W-1:0] sat_inc(input logic [POWER_W-1:0] p,
                                                   input logic [POWER_W-1:0] max_p);
        return (p >= max_p) ? max_p : p + 1'b1;
    endfunction

    // Q1.7 times unsigned magnitude; the negation comes after the shift so the
    // screen-Y flip never changes the rounding direction of the X/Y pair.
    function automatic logic signed [COORD_W-1:0] scale_q(input logic signed [TRIG_W-1:0] q,
                                                          input logic [LEN_W-1:0] mag,
                                                          input logic negate);
        logic signed [PROD_W-1:0] p;
        p = $signed({{(PROD_W-TRIG_W){q[TRIG_W-1]}}, q}) * $signed({{(PROD_W-LEN_W){1'b0}}, mag});
        p = p >>> FRAC_W;
        if (negate) p = -p;
        return p[COORD_W-1:0];
    endfunction

endpackage

// File: rtl/aim_trig_lut.sv
// rtl/aim_trig_lut.sv - registered angle to {cos, sin} Q1.7 ROM, one cycle latency
module aim_trig_lut
    import cue_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ANGLE_W-1:0]       angle_i,
    output logic signed [TRIG_W-1:0] cos_o,
    output logic signed [TRIG_W-1:0] sin_o
);

    // Quarter-wave of round(127*cos(2*pi*i/64)), i = 0..16; other quadrants by symmetry.
    function automatic logic [TRIG_W-1:0] quarter(input logic [4:0] i);
        case (i)
            5'd0:  return 8'd127;
            5'd1:  return 8'd126;
            5'd2:  return 8'd125;
            5'd3:  return 8'd122;
            5'd4:  return 8'd117;
            5'd5:  return 8'd112;
            5'd6:  return 8'd106;
            5'd7:  return 8'd98;
            5'd8:  return 8'd90;
            5'd9:  return 8'd81;
            5'd10: return 8'd71;
            5'd11: return 8'd60;
            5'd12: return 8'd49;
            5'd13: return 8'd37;
            5'd14: return 8'd25;
            5'd15: return 8'd12;
            default: return 8'd0;
        endcase
    endfunction

    logic [TRIG_W-1:0] near_d, far_d, cos_d, sin_d;
    logic signed [TRIG_W-1:0] cos_q, sin_q;

    always_comb begin
        near_d = quarter({1'b0, angle_i[3:0]});
        far_d  = quarter(5'd16 - {1'b0, angle_i[3:0]});
        cos_d  = near_d;
        sin_d  = far_d;
        case (angle_i[5:4])
            2'd0: begin cos_d = near_d;  sin_d = far_d;   end
            2'd1: begin cos_d = -far_d;  sin_d = near_d;  end
            2'd2: begin cos_d = -near_d; sin_d = -far_d;  end
            default: begin cos_d = far_d; sin_d = -near_d; end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cos_q <= '0;
            sin_q <= '0;
        end else begin
            cos_q <= cos_d;
            sin_q <= sin_d;
        end
    end

    assign cos_o = cos_q;
    assign sin_o = sin_q;

endmodule

// File: rtl/cue_aim_controller.sv
// rtl/cue_aim_controller.sv - aim FSM, rotation/power counters and line/shot vector pipeline
module cue_aim_controller
    import cue_pkg::*;
#(
    parameter int ROT_DIV      = 2,
    parameter int MAX_POWER    = 160,
    parameter int LINE_MIN_LEN = 40
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      startOfFrame,
    input  logic                      keyLeft,
    input  logic                      keyRight,
    input  logic                      keyEnterIsPressed,
    input  logic                      ballsStopped,
    output logic                      drawLineEnable,
    output logic signed [COORD_W-1:0] velocityX,
    output logic signed [COORD_W-1:0] velocityY,
    output logic                      shotValid,
    output logic signed [COORD_W-1:0] shotVelocityX,
    output logic signed [COORD_W-1:0] shotVelocityY
);

    cue_state_e               state_q;
    logic [ANGLE_W-1:0]       angle_q, angle_d;
    logic [3:0]               rot_cnt_q, rot_cnt_d;
    logic [POWER_W-1:0]       power_q, power_p_q;
    logic [1:0]               flush_q;
    logic                     armed_q, draw_q, shot_valid_q;
    logic signed [TRIG_W-1:0] cos_q, sin_q;
    logic signed [COORD_W-1:0] vel_x_q, vel_y_q, shot_x_q, shot_y_q;
    logic [LEN_W-1:0]         line_len, shot_mag;

    always_comb begin
        angle_d   = angle_q;
        rot_cnt_d = rot_cnt_q;
        if (state_q == AIM && startOfFrame) begin
            if (keyLeft ^ keyRight) begin
                if (rot_cnt_q == 4'(ROT_DIV - 1)) begin
                    rot_cnt_d = '0;
                    angle_d   = keyLeft ? angle_q + 1'b1 : angle_q - 1'b1;
                end else begin
                    rot_cnt_d = rot_cnt_q + 1'b1;
                end
            end else begin
                rot_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_REST;
            angle_q      <= '0;
            rot_cnt_q    <= '0;
            power_q      <= '0;
            armed_q      <= 1'b0;
            flush_q      <= '0;
            draw_q       <= 1'b0;
            shot_valid_q <= 1'b0;
        end else begin
            angle_q      <= angle_d;
            rot_cnt_q    <= rot_cnt_d;
            shot_valid_q <= 1'b0;
            case (state_q)
                WAIT_REST: begin
                    if (ballsStopped) begin
                        state_q <= AIM;
                        draw_q  <= 1'b1;
                    end
                end
                AIM: begin
                    if (!keyEnterIsPressed) armed_q <= 1'b1;
                    if (!ballsStopped) begin
                        state_q <= WAIT_REST;
                        draw_q  <= 1'b0;
                    end else if (keyEnterIsPressed && armed_q) begin
                        state_q <= CHARGE;
                        power_q <= '0;
                    end
                end
                CHARGE: begin
                    if (startOfFrame) power_q <= sat_inc(power_q, POWER_W'(MAX_POWER));
                    if (!keyEnterIsPressed) begin
                        state_q <= FIRE;
                        draw_q  <= 1'b0;
                        flush_q <= '0;
                    end
                end
                default: begin
                    // Two flush cycles let the frozen angle/power reach the shot registers.
                    if (flush_q != 2'd2) begin
                        flush_q      <= flush_q + 1'b1;
                        shot_valid_q <= (flush_q == 2'd1);
                    end else begin
                        flush_q <= '0;
                        power_q <= '0;
                        armed_q <= 1'b0;
                        state_q <= WAIT_REST;
                    end
                end
            endcase
        end
    end

    aim_trig_lut u_lut (
        .clk     (clk),
        .reset   (reset),
        .angle_i (angle_q),
        .cos_o   (cos_q),
        .sin_o   (sin_q)
    );

    assign line_len = LEN_W'(LINE_MIN_LEN) + {1'b0, power_p_q};
    assign shot_mag = {1'b0, power_p_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            power_p_q <= '0;
            vel_x_q   <= '0;
            vel_y_q   <= '0;
            shot_x_q  <= '0;
            shot_y_q  <= '0;
        end else begin
            power_p_q <= power_q;
            vel_x_q   <= scale_q(cos_q, line_len, 1'b0);
            vel_y_q   <= scale_q(sin_q, line_len, 1'b1);
            shot_x_q  <= scale_q(cos_q, shot_mag, 1'b0);
            shot_y_q  <= scale_q(sin_q, shot_mag, 1'b1);
        end
    end

    assign drawLineEnable = draw_q;
    assign velocityX      = vel_x_q;
    assign velocityY      = vel_y_q;
    assign shotValid      = shot_valid_q;
    assign shotVelocityX  = shot_x_q;
    assign shotVelocityY  = shot_y_q;

endmodule

// File: tb/tb_cue_aim_controller.sv
// tb/tb_cue_aim_controller.sv - directed scoreboard bench for cue_aim_controller
module tb_cue_aim_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic startOfFrame = 1'b0, keyLeft = 1'b0, keyRight = 1'b0;
    logic keyEnterIsPressed = 1'b0, ballsStopped = 1'b0;
    logic drawLineEnable, shotValid;
    logic signed [10:0] velocityX, velocityY, shotVelocityX, shotVelocityY;

    cue_aim_controller dut (
        .clk               (clk),
        .reset             (reset),
        .startOfFrame      (startOfFrame),
        .keyLeft           (keyLeft),
        .keyRight          (keyRight),
        .keyEnterIsPressed (keyEnterIsPressed),
        .ballsStopped      (ballsStopped),
        .drawLineEnable    (drawLineEnable),
        .velocityX         (velocityX),
        .velocityY         (velocityY),
        .shotValid         (shotValid),
        .shotVelocityX     (shotVelocityX),
        .shotVelocityY     (shotVelocityY)
    );

    always #5 clk = ~clk;

    typedef enum int {S_DRAW, S_VX, S_VY, S_SV, S_SVX, S_SVY, S_PULSES, S_CAPX, S_CAPY} sig_e;
    typedef struct {
        string tag;
        sig_e  sig;
        int    val;
    } exp_t;

    exp_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    int pulse_cycles = 0;
    int cap_x = 0;
    int cap_y = 0;

    always @(negedge clk) begin
        if (shotValid === 1'b1) begin
            pulse_cycles++;
            cap_x = int'(shotVelocityX);
            cap_y = int'(shotVelocityY);
        end
    end

    function automatic int trig(int k, bit use_sin);
        real a;
        a = 2.0 * 3.14159265358979 * real'(k) / 64.0;
        return int'(127.0 * (use_sin ? $sin(a) : $cos(a)));
    endfunction

    function automatic int vec(int k, int mag, bit is_y);
        int p;
        p = trig(k, is_y) * mag;
        p = p >>> 7;
        return is_y ? -p : p;
    endfunction

    function automatic int observe(sig_e s);
        case (s)
            S_DRAW:   return (drawLineEnable === 1'b1) ? 1 : (drawLineEnable === 1'b0) ? 0 : -999;
            S_VX:     return int'(velocityX);
            S_VY:     return int'(velocityY);
            S_SV:     return (shotValid === 1'b1) ? 1 : (shotValid === 1'b0) ? 0 : -999;
            S_SVX:    return int'(shotVelocityX);
            S_SVY:    return int'(shotVelocityY);
            S_PULSES: return pulse_cycles;
            S_CAPX:   return cap_x;
            default:  return cap_y;
        endcase
    endfunction

    task automatic push(input string tag, input sig_e s, input int v);
        exp_t e;
        e.tag = tag;
        e.sig = s;
        e.val = v;
        exp_q.push_back(e);
    endtask

    task automatic push_vec(input string tag, input int k, input int mag);
        push({tag, "_vx"}, S_VX, vec(k, mag, 1'b0));
        push({tag, "_vy"}, S_VY, vec(k, mag, 1'b1));
    endtask

    task automatic drain();
        exp_t e;
        int obs;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            obs = observe(e.sig);
            vectors++;
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            tick(1);
            startOfFrame = 1'b0;
            tick(1);
        end
    endtask

    initial begin
        // reset held
        tick(3);
        push("rst_draw", S_DRAW, 0);
        push("rst_vx", S_VX, 0);
        push("rst_vy", S_VY, 0);
        push("rst_sv", S_SV, 0);
        push("rst_svx", S_SVX, 0);
        push("rst_svy", S_SVY, 0);
        drain();

        // balls at rest -> AIM, angle 0, power 0
        reset = 1'b0;
        ballsStopped = 1'b1;
        push("aim0_draw", S_DRAW, 1);
        push_vec("aim0", 0, 40);
        tick(3);
        drain();

        // rotate CCW to angle 16
        keyLeft = 1'b1;
        frames(32);
        keyLeft = 1'b0;
        push_vec("ang16", 16, 40);
        tick(3);
        drain();

        // back to 0, then one Right step wraps to 63
        keyRight = 1'b1;
        frames(32);
        keyRight = 1'b0;
        push_vec("back0", 0, 40);
        tick(3);
        drain();
        keyRight = 1'b1;
        frames(2);
        keyRight = 1'b0;
        push_vec("ang63", 63, 40);
        tick(3);
        drain();

        // both keys held: no rotation
        keyLeft = 1'b1;
        keyRight = 1'b1;
        frames(4);
        keyLeft = 1'b0;
        keyRight = 1'b0;
        push_vec("both", 63, 40);
        tick(3);
        drain();

        // one Left step wraps 63 -> 0
        keyLeft = 1'b1;
        frames(2);
        keyLeft = 1'b0;
        push_vec("wrap0", 0, 40);
        tick(3);
        drain();

        // charge to saturation
        keyEnterIsPressed = 1'b1;
        frames(200);
        push("chg_draw", S_DRAW, 1);
        push_vec("chg_sat", 0, 200);
        push("chg_nopulse", S_PULSES, 0);
        tick(3);
        drain();

        // release -> single shot, balls start moving
        keyEnterIsPressed = 1'b0;
        ballsStopped = 1'b0;
        push("shot_pulses", S_PULSES, 1);
        push("shot_x", S_CAPX, vec(0, 160, 1'b0));
        push("shot_y", S_CAPY, vec(0, 160, 1'b1));
        push("post_draw", S_DRAW, 0);
        push_vec("post_len", 0, 40);
        tick(10);
        drain();

        // Enter held across the next rest: no re-trigger
        keyEnterIsPressed = 1'b1;
        ballsStopped = 1'b1;
        tick(3);
        frames(10);
        push("held_draw", S_DRAW, 1);
        push_vec("held_nochg", 0, 40);
        drain();

        // release and press again -> charge runs
        keyEnterIsPressed = 1'b0;
        tick(2);
        keyEnterIsPressed = 1'b1;
        tick(1);
        frames(10);
        push_vec("rechg10", 0, 50);
        tick(2);
        drain();
        frames(70);
        push_vec("rechg80", 0, 120);
        tick(2);
        drain();

        // reset mid-charge aborts without a shot
        reset = 1'b1;
        push("abort_draw", S_DRAW, 0);
        push("abort_vx", S_VX, 0);
        push("abort_vy", S_VY, 0);
        push("abort_sv", S_SV, 0);
        push("abort_svx", S_SVX, 0);
        tick(1);
        drain();
        keyEnterIsPressed = 1'b0;
        ballsStopped = 1'b0;
        reset = 1'b0;
        push("abort_pulses", S_PULSES, 1);
        push("abort_rest", S_DRAW, 0);
        tick(6);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
